// File: rtl/console_pkg.sv
// Shared geometry, control codes and FSM states for the text console.
package console_pkg;

    localparam int unsigned COLS  = 16;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned IDX_W = $clog2(CELLS);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ROW_W = $clog2(ROWS);

    localparam logic [7:0] BLANK    = 8'h20;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        CLEAR  = 2'd2
    } state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/console_cursor.sv
// Teletype decode: next cursor and cell write for one received byte.
module console_cursor
    import console_pkg::*;
(
    input  logic [7:0]       rx_byte,
    input  logic [IDX_W-1:0] cursor,
    output logic [IDX_W-1:0] nxt_cursor_c,
    output logic             wr_en_c,
    output logic [IDX_W-1:0] wr_idx_c,
    output logic [7:0]       wr_data_c,
    output logic             scroll_req_c,
    output logic             clear_req_c
);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Pure byte/cursor decode; a last-row overflow requests a scroll instead of wrapping.
    always_comb begin
        col          = cursor[COL_W-1:0];
        row          = cursor[IDX_W-1:COL_W];
        nxt_cursor_c = cursor;
        wr_en_c      = 1'b0;
        wr_idx_c     = cursor;
        wr_data_c    = rx_byte;
        scroll_req_c = 1'b0;
        clear_req_c  = 1'b0;

        if (is_printable(rx_byte)) begin
            wr_en_c = 1'b1;
            if (col != COL_W'(COLS - 1)) begin
                nxt_cursor_c = cursor + IDX_W'(1);
            end else if (row != ROW_W'(ROWS - 1)) begin
                nxt_cursor_c = {row + ROW_W'(1), COL_W'(0)};
            end else begin
                scroll_req_c = 1'b1;
                nxt_cursor_c = {ROW_W'(ROWS - 1), COL_W'(0)};
            end
        end else begin
            case (rx_byte)
                CH_CR: nxt_cursor_c = {row, COL_W'(0)};
                CH_LF: begin
                    if (row != ROW_W'(ROWS - 1)) begin
                        nxt_cursor_c = cursor + IDX_W'(COLS);
                    end else begin
                        scroll_req_c = 1'b1;
                    end
                end
                CH_BS: begin
                    if (col != COL_W'(0)) begin
                        nxt_cursor_c = cursor - IDX_W'(1);
                        wr_en_c      = 1'b1;
                        wr_idx_c     = cursor - IDX_W'(1);
                        wr_data_c    = BLANK;
                    end
                end
                CH_FF: begin
                    clear_req_c  = 1'b1;
                    nxt_cursor_c = '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/text_console.sv
// 64-cell screen buffer with CPU cell writes, UART teletype input and a registered read port.
module text_console
    import console_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_we,
    input  logic [IDX_W-1:0] cpu_index,
    input  logic [7:0]       cpu_char,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [7:0]       rd_char,
    output logic [IDX_W-1:0] cursor,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] cursor_q, cursor_d;
    logic [IDX_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic [7:0]       rd_char_q, rd_char_d;
    logic [7:0]       cell_q [CELLS];
    logic [7:0]       cell_d [CELLS];

    logic             accept;
    logic [IDX_W-1:0] dec_cursor;
    logic             dec_wr_en;
    logic [IDX_W-1:0] dec_wr_idx;
    logic [7:0]       dec_wr_data;
    logic             dec_scroll;
    logic             dec_clear;

    // CPU writes take the input port for the cycle, so the UART byte waits.
    assign rx_ready = (state_q == IDLE) && rst_n && !cpu_we;
    assign accept   = rx_valid && rx_ready;

    assign rd_char = rd_char_q;
    assign cursor  = cursor_q;
    assign busy    = busy_q;

    console_cursor u_cursor (
        .rx_byte      (rx_data),
        .cursor       (cursor_q),
        .nxt_cursor_c (dec_cursor),
        .wr_en_c      (dec_wr_en),
        .wr_idx_c     (dec_wr_idx),
        .wr_data_c    (dec_wr_data),
        .scroll_req_c (dec_scroll),
        .clear_req_c  (dec_clear)
    );

    // Next-state, buffer update and cursor; CPU write is applied last so it wins.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cursor_d  = cursor_q;
        pend_d    = pend_q;
        cell_d    = cell_q;
        rd_char_d = cell_q[rd_addr];

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_wr_en) begin
                        cell_d[dec_wr_idx] = dec_wr_data;
                    end
                    if (dec_scroll) begin
                        state_d = SCROLL;
                        row_d   = '0;
                        pend_d  = dec_cursor;
                    end else if (dec_clear) begin
                        state_d = CLEAR;
                        row_d   = '0;
                        pend_d  = dec_cursor;
                    end else begin
                        cursor_d = dec_cursor;
                    end
                end
            end
            SCROLL: begin
                if (row_q == ROW_W'(ROWS - 1)) begin
                    for (int unsigned c = 0; c < COLS; c++) begin
                        cell_d[IDX_W'((ROWS - 1) * COLS + c)] = BLANK;
                    end
                    state_d  = IDLE;
                    cursor_d = pend_q;
                end else begin
                    for (int unsigned c = 0; c < COLS; c++) begin
                        cell_d[IDX_W'(32'(row_q) * COLS + c)] =
                            cell_q[IDX_W'((32'(row_q) + 1) * COLS + c)];
                    end
                end
                row_d = row_q + ROW_W'(1);
            end
            CLEAR: begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    cell_d[IDX_W'(32'(row_q) * COLS + c)] = BLANK;
                end
                if (row_q == ROW_W'(ROWS - 1)) begin
                    state_d  = IDLE;
                    cursor_d = pend_q;
                end
                row_d = row_q + ROW_W'(1);
            end
            default: state_d = IDLE;
        endcase

        if (cpu_we) begin
            cell_d[cpu_index] = cpu_char;
        end

        busy_d = (state_d != IDLE);
    end

    // State and buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            cursor_q  <= '0;
            pend_q    <= '0;
            busy_q    <= 1'b0;
            rd_char_q <= BLANK;
            for (int unsigned i = 0; i < CELLS; i++) begin
                cell_q[i] <= BLANK;
            end
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            cursor_q  <= cursor_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            rd_char_q <= rd_char_d;
            for (int unsigned i = 0; i < CELLS; i++) begin
                cell_q[i] <= cell_d[i];
            end
        end
    end

endmodule
